// File: rtl/sync_phase_scan.sv
// Detector-phase scan controller: steps the detector phase, runs one auto-sync
// measurement per step and reports the first phase at which t0 changes.
module sync_phase_scan #(
  parameter int TIME_BITS     = 8,
  parameter int PHASE_BITS    = 12,
  parameter int STEP_BITS     = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int WAIT_MAX      = 65535
) (
  input  logic                    clock_IO,
  input  logic                    reset_IO,
  input  logic                    scan_start,
  input  logic                    scan_abort,
  input  logic                    prim,
  input  logic [PHASE_BITS-1:0]   phase_ext,
  input  logic [PHASE_BITS-1:0]   phase_first,
  input  logic [PHASE_BITS-1:0]   phase_step,
  input  logic [STEP_BITS-1:0]    steps,
  output logic [2*PHASE_BITS-1:0] ps_phase,
  output logic                    ps_start,
  input  logic                    ps_active,
  output logic                    as_en,
  output logic                    as_prim,
  input  logic                    as_active,
  input  logic                    as_timeout,
  input  logic [4*TIME_BITS-1:0]  sync_time,
  output logic                    scan_busy,
  output logic                    scan_done,
  output logic                    scan_error,
  output logic                    edge_found,
  output logic [PHASE_BITS-1:0]   edge_phase,
  output logic [TIME_BITS-1:0]    edge_t0,
  output logic [STEP_BITS-1:0]    step_index
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PS_REQ  = 3'd1,
    S_PS_WAIT = 3'd2,
    S_SETTLE  = 3'd3,
    S_AS_RUN  = 3'd4,
    S_EVAL    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [16:0] WAIT_LIMIT  = 17'(WAIT_MAX);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] PS_MIN_LAST = 16'd3;
  localparam logic [15:0] AS_MIN_LAST = 16'd1;

  state_t                  state, state_nxt;
  logic [15:0]             cnt, cnt_nxt;
  logic [STEP_BITS-1:0]    k, k_nxt;
  logic [STEP_BITS-1:0]    steps_l, steps_l_nxt;
  logic [PHASE_BITS-1:0]   det, det_nxt;
  logic [PHASE_BITS-1:0]   ext, ext_nxt;
  logic [PHASE_BITS-1:0]   step_inc, step_inc_nxt;
  logic [TIME_BITS-1:0]    ref_t0, ref_t0_nxt;
  logic [2*PHASE_BITS-1:0] ps_phase_nxt;
  logic                    ps_start_nxt, as_en_nxt;
  logic                    busy_nxt, done_nxt, error_nxt, found_nxt;
  logic [PHASE_BITS-1:0]   edge_phase_nxt;
  logic [TIME_BITS-1:0]    edge_t0_nxt;
  logic [STEP_BITS-1:0]    step_index_nxt;

  logic [TIME_BITS-1:0]    t0;
  logic [PHASE_BITS-1:0]   det_inc;
  logic [16:0]             cnt_inc;
  logic                    wait_expired;
  logic                    unused_sync;

  assign t0           = sync_time[TIME_BITS-1:0];
  assign unused_sync  = ^sync_time[4*TIME_BITS-1:TIME_BITS];
  assign det_inc      = det + step_inc;
  assign cnt_inc      = {1'b0, cnt} + 17'd1;
  assign wait_expired = (cnt_inc >= WAIT_LIMIT);

  // State register and all registered outputs.
  always_ff @(posedge clock_IO or posedge reset_IO) begin
    if (reset_IO) begin
      state      <= S_IDLE;
      cnt        <= 16'd0;
      k          <= '0;
      steps_l    <= '0;
      det        <= '0;
      ext        <= '0;
      step_inc   <= '0;
      ref_t0     <= '0;
      ps_phase   <= '0;
      ps_start   <= 1'b0;
      as_en      <= 1'b0;
      as_prim    <= 1'b0;
      scan_busy  <= 1'b0;
      scan_done  <= 1'b0;
      scan_error <= 1'b0;
      edge_found <= 1'b0;
      edge_phase <= '0;
      edge_t0    <= '0;
      step_index <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      k          <= k_nxt;
      steps_l    <= steps_l_nxt;
      det        <= det_nxt;
      ext        <= ext_nxt;
      step_inc   <= step_inc_nxt;
      ref_t0     <= ref_t0_nxt;
      ps_phase   <= ps_phase_nxt;
      ps_start   <= ps_start_nxt;
      as_en      <= as_en_nxt;
      as_prim    <= prim;
      scan_busy  <= busy_nxt;
      scan_done  <= done_nxt;
      scan_error <= error_nxt;
      edge_found <= found_nxt;
      edge_phase <= edge_phase_nxt;
      edge_t0    <= edge_t0_nxt;
      step_index <= step_index_nxt;
    end
  end

  // Next-state, handshake timing, watchdog and result update.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    k_nxt          = k;
    steps_l_nxt    = steps_l;
    det_nxt        = det;
    ext_nxt        = ext;
    step_inc_nxt   = step_inc;
    ref_t0_nxt     = ref_t0;
    ps_phase_nxt   = ps_phase;
    busy_nxt       = scan_busy;
    done_nxt       = 1'b0;
    error_nxt      = scan_error;
    found_nxt      = edge_found;
    edge_phase_nxt = edge_phase;
    edge_t0_nxt    = edge_t0;
    step_index_nxt = step_index;

    case (state)
      S_IDLE: begin
        if (scan_start) begin
          ext_nxt        = phase_ext;
          det_nxt        = phase_first;
          step_inc_nxt   = phase_step;
          steps_l_nxt    = steps;
          k_nxt          = '0;
          cnt_nxt        = 16'd0;
          error_nxt      = 1'b0;
          found_nxt      = 1'b0;
          edge_phase_nxt = '0;
          edge_t0_nxt    = '0;
          step_index_nxt = '0;
          if (steps == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt    = S_PS_REQ;
            busy_nxt     = 1'b1;
            ps_phase_nxt = {phase_ext, phase_first};
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_PS_REQ: begin
        cnt_nxt   = 16'd0;
        state_nxt = S_PS_WAIT;
      end
      S_PS_WAIT: begin
        if ((cnt >= PS_MIN_LAST) && !ps_active) begin
          cnt_nxt   = 16'd0;
          state_nxt = S_SETTLE;
        end else if (wait_expired) begin
          error_nxt = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt_inc[15:0];
        end
      end
      S_SETTLE: begin
        if (cnt >= SETTLE_LAST) begin
          cnt_nxt   = 16'd0;
          state_nxt = S_AS_RUN;
        end else begin
          cnt_nxt = cnt_inc[15:0];
        end
      end
      S_AS_RUN: begin
        if ((cnt >= AS_MIN_LAST) && !as_active) begin
          cnt_nxt   = 16'd0;
          state_nxt = S_EVAL;
        end else if (wait_expired) begin
          error_nxt = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt_inc[15:0];
        end
      end
      S_EVAL: begin
        // The first step's t0 is the reference every later step is compared with.
        if (as_timeout) begin
          error_nxt = 1'b1;
          state_nxt = S_DONE;
        end else if ((k != '0) && (t0 != ref_t0)) begin
          found_nxt      = 1'b1;
          edge_phase_nxt = det;
          edge_t0_nxt    = t0;
          state_nxt      = S_DONE;
        end else begin
          if (k == '0) begin
            ref_t0_nxt = t0;
          end else begin
            ref_t0_nxt = ref_t0;
          end
          if (k == (steps_l - STEP_BITS'(1))) begin
            state_nxt = S_DONE;
          end else begin
            k_nxt          = k + STEP_BITS'(1);
            step_index_nxt = k + STEP_BITS'(1);
            det_nxt        = det_inc;
            ps_phase_nxt   = {ext, det_inc};
            state_nxt      = S_PS_REQ;
          end
        end
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    // Abort wins over every transition and leaves results as they were.
    if (scan_abort && (state != S_IDLE)) begin
      state_nxt      = S_IDLE;
      busy_nxt       = 1'b0;
      done_nxt       = 1'b0;
      error_nxt      = scan_error;
      found_nxt      = edge_found;
      edge_phase_nxt = edge_phase;
      edge_t0_nxt    = edge_t0;
      step_index_nxt = step_index;
    end else begin
      busy_nxt = busy_nxt;
    end

    ps_start_nxt = (state_nxt == S_PS_REQ);
    as_en_nxt    = (state_nxt == S_AS_RUN);
  end

endmodule

// File: doc/sync_phase_scan.md
# sync_phase_scan

Automatic detector-phase scan controller on the clock_IO side, directly upstream of the auto-sync block. It steps the detector-clock phase over a programmed range. For each step it applies the phase via ps_start and ps_phase, runs one auto-sync measurement via as_en, and compares the measured t0 against the first step's value. It reports the first phase at which t0 changes (the sampling edge), or an error on auto-sync timeout or handshake watchdog.

## Interface
- TIME_BITS, 8: width of each of the four sync_time fields
- PHASE_BITS, 12: width of each phase word
- STEP_BITS, 8: width of step count and step index
- SETTLE_CYCLES, 16: idle cycles after each phase shift before starting auto-sync (≥1)
- WAIT_MAX, 65535: watchdog limit in cycles per handshake wait (fits in 16 bits)

Ports:
- clock_IO  in  1  register/control clock; the only clock
- reset_IO  in  1  asynchronous, active-high reset
- scan_start  in  1  one-cycle start pulse
- scan_abort  in  1  one-cycle abort pulse
- prim  in  1  primary-board select, forwarded to as_prim
- phase_ext  in  PHASE_BITS  external-clock phase, held constant during the scan
- phase_first  in  PHASE_BITS  detector phase of step 0
- phase_step  in  PHASE_BITS  detector phase increment per step
- steps  in  STEP_BITS  number of steps to measure
- ps_phase  out  2*PHASE_BITS  {ext, det} phase to the auto-sync block
- ps_start  out  1  one-cycle phase-shift request
- ps_active  in  1  phase shift in progress
- as_en  out  1  auto-sync enable, held high for one measurement
- as_prim  out  1  registered copy of prim
- as_active  in  1  auto-sync running
- as_timeout  in  1  auto-sync timeout status
- sync_time  in  4*TIME_BITS  {t1_PS, t0_PS, t1, t0}
- scan_busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse at scan end
- scan_error  out  1  last scan ended on timeout or watchdog
- edge_found  out  1  last scan found a t0 change
- edge_phase  out  PHASE_BITS  detector phase where t0 first changed
- edge_t0  out  TIME_BITS  t0 value measured at edge_phase
- step_index  out  STEP_BITS  current (busy) or last completed step

## Operation
- Reset value 0 for every output and internal register.
- Register capture on accepted scan_start: all inputs latched; scan_error, edge_found, edge_phase, edge_t0 and step_index cleared.
- While busy, phase arithmetic is det = phase_first + k·phase_step, modulo 2^PHASE_BITS (unsigned wrap), and ps_phase = {phase_ext, det}.
- IDLE:
  - On scan_start: go to PS_REQ. scan_busy rises the next cycle.
  - If steps==0: go to DONE instead; no handshakes are issued.
- PS_REQ: update ps_phase and assert ps_start for exactly one cycle, then go to PS_WAIT.
- PS_WAIT:
  - Wait at least 4 cycles, then wait until ps_active==0. Then go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to AS_RUN.
- AS_RUN: raise as_en and keep it high.
  - Wait at least 2 cycles, then wait until as_active==0. Then go to EVAL.
- EVAL:
  - Drop as_en and sample sync_time and as_timeout.
  - If as_timeout=1: set scan_error=1 and go to DONE.
  - If k==0: store ref_t0 = t0.
  - If k>0 and t0≠ref_t0: set edge_found=1, edge_phase=det, edge_t0=t0, and go to DONE.
  - Otherwise, if k==steps-1: go to DONE.
  - Otherwise: increment k and go to PS_REQ.
- DONE: pulse scan_done for one cycle, clear scan_busy, return to IDLE.
- Results hold until the next accepted scan_start.
- Watchdog: a per-wait counter in PS_WAIT and AS_RUN.
  - Reaching WAIT_MAX sets scan_error=1, drops as_en and goes to DONE.
- Abort: scan_abort in any busy state takes priority over every transition.
  - Drops as_en and ps_start and returns to IDLE the next cycle.
  - No scan_done pulse; result outputs keep their current values.
- scan_start while busy is ignored. scan_start and scan_abort together in IDLE: the scan starts.
- ps_phase holds the last applied value after the scan ends.
- step_index = k, updated when entering PS_REQ.

## Timing
- scan_start accepted at edge N:
  - scan_busy=1 and PS_REQ entered at N+1.
  - ps_start high during cycle N+1 only; ps_phase valid from N+1.
- as_en is low for at least one cycle between consecutive steps, so the downstream rising-edge detector always fires.
- sync_time and as_timeout are sampled the cycle after as_active==0 is seen (downstream output CDC already settled).
- Minimum step duration: 1 + 4 + SETTLE_CYCLES + 2 + 1 cycles plus downstream latency.
- steps==0: scan_done pulses at N+2; scan_busy stays 0.
- scan_done is coincident with scan_busy falling. All result outputs are stable when scan_done=1.
- Asynchronous reset mid-scan: all outputs go to 0 immediately, including as_en and ps_start.

## Test plan
- phase_first=0, phase_step=10, steps=4; model t0=5 for all steps -> 4 ps_start pulses with det 0, 10, 20, 30; scan_done; edge_found=0; step_index=3.
- Same setup, model t0 becomes 6 at step 2 -> edge_found=1, edge_phase=20, edge_t0=6, only 3 measurements run.
- phase_first=4090, phase_step=10 (PHASE_BITS=12) -> det sequence 4090, 4, 14 (wrap verified).
- Model as_timeout=1 at step 1 -> scan_error=1, scan_done pulse, as_en low, no step-2 ps_start.
- Model ps_active stuck high, WAIT_MAX=100 -> scan_error=1 after 100 wait cycles. Also: scan_abort during AS_RUN -> as_en low next cycle, no scan_done, results unchanged.
- reset_IO asserted mid-SETTLE -> all outputs 0 asynchronously; steps=0 start -> scan_done at N+2 with no ps_start and no as_en.
